// File: rtl/read_requester.sv
`default_nettype none
// ============================================================================
// read_requester : initiator for the rd/rd_data/ack read handshake; runs bursts
// of len reads, counts completions, aborts on protocol error or stall.
// Revision: 1.0
// ============================================================================
module read_requester #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             rd_data,
  input  logic             ack,
  output logic             rd,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic             err_proto,
  output logic [LEN_W-1:0] xfer_cnt
);

  // TIMEOUT-1 always fits in clog2(TIMEOUT) bits for TIMEOUT >= 4
  localparam int               TMR_W   = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_REL      = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             rd_q, rd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_timeout_q, err_timeout_d;
  logic             err_proto_q, err_proto_d;
  logic [LEN_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             tmr_expired;

  assign tmr_expired = (timer_q == TMR_MAX);

  always_comb begin
    state_d       = state_q;
    done_d        = 1'b0;
    err_timeout_d = err_timeout_q;
    err_proto_d   = err_proto_q;
    xfer_cnt_d    = xfer_cnt_q;
    remain_d      = remain_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remain_d      = len;
          xfer_cnt_d    = '0;
          err_timeout_d = 1'b0;
          err_proto_d   = 1'b0;
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        // rd_data takes priority; ack without it is a violation, which beats timeout
        if (rd_data) begin
          state_d = ST_WAIT_ACK;
        end else if (ack) begin
          err_proto_d = 1'b1;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end else if (tmr_expired) begin
          err_timeout_d = 1'b1;
          done_d        = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      ST_WAIT_ACK: begin
        if (ack) begin
          xfer_cnt_d = xfer_cnt_q + LEN_W'(1);
          remain_d   = remain_q - LEN_W'(1);
          state_d    = ST_REL;
        end else if (tmr_expired) begin
          err_timeout_d = 1'b1;
          done_d        = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      ST_REL: begin
        if (!ack) begin
          if (remain_q == '0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_REQ;
          end
        end else if (tmr_expired) begin
          err_timeout_d = 1'b1;
          done_d        = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_d   = (state_d == ST_REQ) || (state_d == ST_WAIT_ACK);
    busy_d = (state_d != ST_IDLE);

    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      rd_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_proto_q   <= 1'b0;
      xfer_cnt_q    <= '0;
      remain_q      <= '0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      rd_q          <= rd_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_timeout_q <= err_timeout_d;
      err_proto_q   <= err_proto_d;
      xfer_cnt_q    <= xfer_cnt_d;
      remain_q      <= remain_d;
      timer_q       <= timer_d;
    end
  end

  assign rd          = rd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = err_timeout_q;
  assign err_proto   = err_proto_q;
  assign xfer_cnt    = xfer_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_read_requester.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_read_requester : directed bench with a cycle-level responder model.
// Revision: 1.0
// ============================================================================
module tb_read_requester;

  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 16;

  logic             clk     = 1'b0;
  logic             rst     = 1'b1;
  logic             start   = 1'b0;
  logic [LEN_W-1:0] len     = '0;
  logic             rd_data = 1'b0;
  logic             ack     = 1'b0;
  logic             rd, busy, done, err_timeout, err_proto;
  logic [LEN_W-1:0] xfer_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  typedef enum logic [1:0] {R_IDLE, R_READ, R_ACK} rsp_t;
  rsp_t rsp_st    = R_IDLE;
  int   rsp_mode  = 0;     // 0 compliant, 1 acks without rd_data, 2 forced values
  int   acks_left = 1000;  // responder goes deaf to rd after this many acks
  logic frc_rd_data = 1'b0;
  logic frc_ack     = 1'b0;

  always #5 clk = ~clk;

  read_requester #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .rd_data     (rd_data),
    .ack         (ack),
    .rd          (rd),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .err_proto   (err_proto),
    .xfer_cnt    (xfer_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // One clock: the responder reacts to the rd value seen before the edge.
  task automatic tick();
    logic rd_seen;
    rd_seen = rd;
    @(posedge clk);
    #1;
    case (rsp_st)
      R_IDLE: if (rd_seen === 1'b1 && acks_left > 0) rsp_st = (rsp_mode == 1) ? R_ACK : R_READ;
      R_READ: rsp_st = R_ACK;
      R_ACK:  if (rd_seen !== 1'b1) rsp_st = R_IDLE;
      default: rsp_st = R_IDLE;
    endcase
    if (rsp_st == R_ACK && (rd_seen === 1'b1) && ack == 1'b0) acks_left--;
    if (rsp_mode == 2) begin
      rd_data = frc_rd_data;
      ack     = frc_ack;
    end else begin
      rd_data = (rsp_st == R_READ);
      ack     = (rsp_st == R_ACK);
    end
  endtask

  initial begin
    // reset held with responder lines toggling
    rsp_mode = 2;
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      frc_rd_data = i[0];
      frc_ack     = ~i[0];
      tick();
    end
    check("rst_rd", 32'(rd), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err_t", 32'(err_timeout), 0);
    check("rst_err_p", 32'(err_proto), 0);
    check("rst_xfer", 32'(xfer_cnt), 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      frc_rd_data = ~i[0];
      frc_ack     = i[0];
      tick();
      check("idle_rd", 32'(rd), 0);
      check("idle_busy", 32'(busy), 0);
    end
    rsp_mode = 0; rsp_st = R_IDLE; rd_data = 1'b0; ack = 1'b0;
    tick();

    // len=3 compliant burst; len is changed right after acceptance
    len = 4'd3; start = 1'b1;
    tick();
    start = 1'b0; len = 4'd0;
    check("b3_rd_s", 32'(rd), 1);
    check("b3_busy_s", 32'(busy), 1);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("b3_rd", 32'(rd), 32'((k < 15) && ((k % 5) < 3)));
      check("b3_xfer", 32'(xfer_cnt), 32'((k >= 3) + (k >= 8) + (k >= 13)));
      check("b3_done", 32'(done), 32'(k == 15));
      check("b3_busy", 32'(busy), 32'(k < 15));
    end
    check("b3_err_t", 32'(err_timeout), 0);
    check("b3_err_p", 32'(err_proto), 0);

    // len=0
    len = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("l0_done", 32'(done), 1);
    check("l0_busy", 32'(busy), 0);
    check("l0_rd", 32'(rd), 0);
    check("l0_xfer", 32'(xfer_cnt), 0);
    tick();
    check("l0_done_end", 32'(done), 0);
    check("l0_rd_end", 32'(rd), 0);

    // protocol violation: ack without rd_data
    rsp_mode = 1; acks_left = 1000;
    len = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pr_busy", 32'(busy), 1);
    check("pr_err_early", 32'(err_proto), 0);
    tick();
    check("pr_err_p", 32'(err_proto), 1);
    check("pr_err_t", 32'(err_timeout), 0);
    check("pr_rd", 32'(rd), 0);
    check("pr_done", 32'(done), 1);
    check("pr_busy_end", 32'(busy), 0);
    check("pr_xfer", 32'(xfer_cnt), 0);
    tick();
    check("pr_done_end", 32'(done), 0);
    check("pr_sticky", 32'(err_proto), 1);
    rsp_mode = 0;
    tick(); tick();

    // timeout: responder goes deaf after the first ack
    acks_left = 1;
    len = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("to_clr_p", 32'(err_proto), 0);
    check("to_busy_s", 32'(busy), 1);
    for (int k = 1; k <= 21; k++) begin
      tick();
      if (k == 5) begin
        check("to_req2_rd", 32'(rd), 1);
        check("to_req2_xfer", 32'(xfer_cnt), 1);
      end
      if (k == 20) begin
        check("to_pre_busy", 32'(busy), 1);
        check("to_pre_err", 32'(err_timeout), 0);
        check("to_pre_rd", 32'(rd), 1);
      end
    end
    check("to_err_t", 32'(err_timeout), 1);
    check("to_err_p", 32'(err_proto), 0);
    check("to_done", 32'(done), 1);
    check("to_rd", 32'(rd), 0);
    check("to_busy", 32'(busy), 0);
    check("to_xfer", 32'(xfer_cnt), 1);
    tick();
    check("to_sticky", 32'(err_timeout), 1);

    // next start clears the timeout flag
    acks_left = 1000;
    len = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("cl_err_t", 32'(err_timeout), 0);
    check("cl_xfer", 32'(xfer_cnt), 0);
    for (int k = 1; k <= 5; k++) tick();
    check("cl_done", 32'(done), 1);
    check("cl_xfer_end", 32'(xfer_cnt), 1);
    tick();

    // reset mid-burst, with a start pulse while busy
    len = 4'd5; start = 1'b1;
    tick();
    len = 4'd1;
    tick();
    start = 1'b0;
    check("rb_busy", 32'(busy), 1);
    check("rb_rd", 32'(rd), 1);
    for (int k = 2; k <= 5; k++) tick();
    check("rb_ign_done", 32'(done), 0);
    check("rb_ign_busy", 32'(busy), 1);
    check("rb_req2_rd", 32'(rd), 1);
    tick(); tick();
    check("rb_wait_xfer", 32'(xfer_cnt), 1);
    check("rb_wait_rd", 32'(rd), 1);
    #2 rst = 1'b0;
    #1;
    rsp_st = R_IDLE; rd_data = 1'b0; ack = 1'b0;
    check("rb_async_rd", 32'(rd), 0);
    check("rb_async_busy", 32'(busy), 0);
    check("rb_async_done", 32'(done), 0);
    check("rb_async_xfer", 32'(xfer_cnt), 0);
    tick();
    check("rb_hold_done", 32'(done), 0);
    rst = 1'b1;
    tick();
    check("rb_rel_done", 32'(done), 0);
    check("rb_rel_busy", 32'(busy), 0);
    check("rb_rel_rd", 32'(rd), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
